// File: rtl/riscv_pkg.sv
// Shared RV32I encodings: opcodes, funct3 values and the ALU operation set.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   // alt is instruction bit 30: selects SUB over ADD and SRA over SRL
   function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         F3_AND:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational 32-bit integer ALU for the RV32I OP and OP-IMM groups.
module riscv_alu
   import riscv_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_e     op_i,
   output logic [31:0] y_o
);

   always_comb begin
      y_o = 32'd0;
      case (op_i)
         ALU_ADD:  y_o = a_i + b_i;
         ALU_SUB:  y_o = a_i - b_i;
         ALU_SLL:  y_o = a_i << b_i[4:0];
         ALU_SLT:  y_o = {31'd0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: y_o = {31'd0, a_i < b_i};
         ALU_XOR:  y_o = a_i ^ b_i;
         ALU_SRL:  y_o = a_i >> b_i[4:0];
         ALU_SRA:  y_o = 32'($signed(a_i) >>> b_i[4:0]);
         ALU_OR:   y_o = a_i | b_i;
         ALU_AND:  y_o = a_i & b_i;
         default:  y_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/riscv_cpu.sv
// Single-cycle RV32I core: decode, register file, immediates, load/store
// formatting (SB/SH as read-modify-write) and next-PC selection.
module riscv_cpu
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] inst,
   input  logic [31:0] load_data,
   output logic        mem_load,
   output logic        mem_store,
   output logic [31:0] store_data,
   output logic [31:0] address,
   output logic [31:0] pc
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] regs_q [32];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, pc_plus4, mem_addr;
   logic [31:0] alu_b, alu_y, rd_wdata, ld_val, st_val;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [4:0]  lane_sh;
   alu_op_e     alu_op;
   logic        rd_we, is_load, is_store, br_taken, ld_ok, st_ok, imm_ok, op_ok;

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign funct3 = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign funct7 = inst[31:25];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'd0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
   assign pc_plus4 = pc_q + 32'd4;
   assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

   assign ld_ok  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                   (funct3 == F3_BU) || (funct3 == F3_HU);
   assign st_ok  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
   assign imm_ok = (funct3 == F3_SLL) ? (funct7 == 7'd0) :
                   (funct3 == F3_SR)  ? ((funct7 == 7'd0) || (funct7 == 7'b0100000)) : 1'b1;
   assign op_ok  = (funct7 == 7'd0) ||
                   ((funct7 == 7'b0100000) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));

   riscv_alu u_alu (
      .a_i  (rs1_val),
      .b_i  (alu_b),
      .op_i (alu_op),
      .y_o  (alu_y)
   );

   // Branch condition evaluation
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = (rs1_val == rs2_val);
         F3_BNE:  br_taken = (rs1_val != rs2_val);
         F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
         F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         F3_BLTU: br_taken = (rs1_val < rs2_val);
         F3_BGEU: br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   assign lane_sh  = {mem_addr[1:0], 3'b000};
   assign byte_sel = 8'(load_data >> lane_sh);
   assign half_sel = mem_addr[1] ? load_data[31:16] : load_data[15:0];

   // Load extraction and store merge; SB/SH rebuild the whole word from load_data
   always_comb begin
      ld_val = load_data;
      st_val = rs2_val;
      case (funct3)
         F3_B: begin
            ld_val = {{24{byte_sel[7]}}, byte_sel};
            st_val = (load_data & ~(32'h0000_00FF << lane_sh)) | ({24'd0, rs2_val[7:0]} << lane_sh);
         end
         F3_H: begin
            ld_val = {{16{half_sel[15]}}, half_sel};
            st_val = mem_addr[1] ? {rs2_val[15:0], load_data[15:0]} : {load_data[31:16], rs2_val[15:0]};
         end
         F3_BU:   ld_val = {24'd0, byte_sel};
         F3_HU:   ld_val = {16'd0, half_sel};
         default: ld_val = load_data;
      endcase
   end

   // Main decode: write-back, memory intent and next PC
   always_comb begin
      rd_we    = 1'b0;
      rd_wdata = alu_y;
      alu_b    = imm_i;
      alu_op   = ALU_ADD;
      is_load  = 1'b0;
      is_store = 1'b0;
      pc_d     = pc_plus4;
      case (opcode)
         OPC_LUI: begin
            rd_we    = 1'b1;
            rd_wdata = imm_u;
         end
         OPC_AUIPC: begin
            rd_we    = 1'b1;
            rd_wdata = pc_q + imm_u;
         end
         OPC_JAL: begin
            rd_we    = 1'b1;
            rd_wdata = pc_plus4;
            pc_d     = pc_q + imm_j;
         end
         OPC_JALR: begin
            if (funct3 == 3'd0) begin
               rd_we    = 1'b1;
               rd_wdata = pc_plus4;
               pc_d     = (rs1_val + imm_i) & ~32'd1;
            end else begin
               rd_we = 1'b0;
            end
         end
         OPC_BRANCH: begin
            if (br_taken) begin
               pc_d = pc_q + imm_b;
            end else begin
               pc_d = pc_plus4;
            end
         end
         OPC_LOAD: begin
            is_load  = ld_ok;
            rd_we    = ld_ok;
            rd_wdata = ld_val;
         end
         OPC_STORE: is_store = st_ok;
         OPC_OP_IMM: begin
            alu_op = alu_op_from(funct3, inst[30] && (funct3 == F3_SR));
            rd_we  = imm_ok;
         end
         OPC_OP: begin
            alu_b  = rs2_val;
            alu_op = alu_op_from(funct3, inst[30]);
            rd_we  = op_ok;
         end
         default: rd_we = 1'b0;
      endcase
   end

   assign mem_load   = ~reset & (is_load | (is_store & (funct3 != F3_W)));
   assign mem_store  = ~reset & is_store;
   assign address    = (mem_load | mem_store) ? mem_addr : 32'd0;
   assign store_data = mem_store ? st_val : 32'd0;
   assign pc         = pc_q;

   // PC register
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Register file write port; x0 is never written
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else if (rd_we && (rd != 5'd0)) begin
         regs_q[rd] <= rd_wdata;
      end
   end

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed vector bench for riscv_cpu with a small word-wide data memory.
module tb_riscv_cpu;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] inst;
   logic [31:0] load_data;
   logic        mem_load, mem_store;
   logic [31:0] store_data, address, pc;

   logic [31:0] dmem [256];
   bit          mem_inited = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        rst;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [31:0] sd;
      string       name;
   } vec_t;

   vec_t vecs[$];

   riscv_cpu #(.RESET_PC(32'h0000_0000)) dut (
      .clock      (clock),
      .reset      (reset),
      .inst       (inst),
      .load_data  (load_data),
      .mem_load   (mem_load),
      .mem_store  (mem_store),
      .store_data (store_data),
      .address    (address),
      .pc         (pc)
   );

   always #5 clock = ~clock;

   assign load_data = dmem[address[9:2]];

   always @(posedge clock) begin
      if (!mem_inited) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
         dmem[64]   <= 32'h1122_3344;
         mem_inited <= 1'b1;
      end else if (mem_store) begin
         dmem[address[9:2]] <= store_data;
      end
   end

   function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic add(logic rst, logic [31:0] in, logic [31:0] p, logic ld, logic st,
                      logic [31:0] a, logic [31:0] sd, string nm);
      vec_t v;
      v.rst = rst; v.inst = in; v.pc = p; v.ld = ld; v.st = st;
      v.addr = a; v.sd = sd; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic check(string nm, string fld, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
      end
   endtask

   task automatic check_vec(vec_t v);
      vectors++;
      check(v.name, "pc", pc, v.pc);
      check(v.name, "mem_load", {31'd0, mem_load}, {31'd0, v.ld});
      check(v.name, "mem_store", {31'd0, mem_store}, {31'd0, v.st});
      check(v.name, "address", address, v.addr);
      if (v.st || v.rst) check(v.name, "store_data", store_data, v.sd);
   endtask

   initial begin
      bit found;
      vec_t hv;

      //  rst  inst                                  pc     ld st addr           store_data
      add(1, NOP,                                    32'h00, 0, 0, 32'h0,        32'h0,         "reset_idle");
      add(0, NOP,                                    32'h00, 0, 0, 32'h0,        32'h0,         "nop0");
      add(0, NOP,                                    32'h04, 0, 0, 32'h0,        32'h0,         "nop4");
      add(0, NOP,                                    32'h08, 0, 0, 32'h0,        32'h0,         "nop8");
      add(0, NOP,                                    32'h0C, 0, 0, 32'h0,        32'h0,         "nopC");
      add(0, enc_b(32'd8, 5'd0, 5'd0, 3'd0),         32'h10, 0, 0, 32'h0,        32'h0,         "beq_taken");
      add(0, enc_i(32'hFFF, 5'd0, 3'd0, 5'd1, OP_IMM), 32'h18, 0, 0, 32'h0,      32'h0,         "addi_m1");
      add(0, enc_i(32'h004, 5'd1, 3'd5, 5'd2, OP_IMM), 32'h1C, 0, 0, 32'h0,      32'h0,         "srli");
      add(0, enc_i(32'h404, 5'd1, 3'd5, 5'd3, OP_IMM), 32'h20, 0, 0, 32'h0,      32'h0,         "srai");
      add(0, enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4),   32'h24, 0, 0, 32'h0,        32'h0,         "sltu");
      add(0, enc_s(32'd0, 5'd2, 5'd0, 3'd2),         32'h28, 0, 1, 32'h0,        32'h0FFF_FFFF, "sw_x2");
      add(0, enc_s(32'd4, 5'd3, 5'd0, 3'd2),         32'h2C, 0, 1, 32'h4,        32'hFFFF_FFFF, "sw_x3");
      add(0, enc_s(32'd8, 5'd4, 5'd0, 3'd2),         32'h30, 0, 1, 32'h8,        32'h1,         "sw_x4");
      add(0, {20'h20000, 5'd5, 7'b0110111},          32'h34, 0, 0, 32'h0,        32'h0,         "lui");
      add(0, enc_i(32'd1, 5'd0, 3'd0, 5'd6, OP_IMM), 32'h38, 0, 0, 32'h0,        32'h0,         "addi_1");
      add(0, enc_s(32'd0, 5'd6, 5'd5, 3'd2),         32'h3C, 0, 1, 32'h2000_0000, 32'h1,        "sw_hi");
      add(0, enc_i(32'hAA, 5'd0, 3'd0, 5'd7, OP_IMM), 32'h40, 0, 0, 32'h0,       32'h0,         "addi_aa");
      add(0, enc_i(32'h100, 5'd0, 3'd0, 5'd8, OP_IMM), 32'h44, 0, 0, 32'h0,      32'h0,         "addi_100");
      add(0, enc_s(32'd1, 5'd7, 5'd8, 3'd0),         32'h48, 1, 1, 32'h101,      32'h1122_AA44, "sb_rmw");
      add(0, enc_i(32'd1, 5'd8, 3'd0, 5'd9, OP_LD),  32'h4C, 1, 0, 32'h101,      32'h0,         "lb");
      add(0, enc_i(32'd1, 5'd8, 3'd4, 5'd10, OP_LD), 32'h50, 1, 0, 32'h101,      32'h0,         "lbu");
      add(0, enc_s(32'd0, 5'd9, 5'd0, 3'd2),         32'h54, 0, 1, 32'h0,        32'hFFFF_FFAA, "lb_val");
      add(0, enc_s(32'd0, 5'd10, 5'd0, 3'd2),        32'h58, 0, 1, 32'h0,        32'h0000_00AA, "lbu_val");
      add(0, enc_i(32'd0, 5'd8, 3'd2, 5'd11, OP_LD), 32'h5C, 1, 0, 32'h100,      32'h0,         "lw");
      add(0, enc_s(32'd0, 5'd11, 5'd0, 3'd2),        32'h60, 0, 1, 32'h0,        32'h1122_AA44, "lw_val");
      add(0, enc_s(32'd2, 5'd1, 5'd8, 3'd1),         32'h64, 1, 1, 32'h102,      32'hFFFF_AA44, "sh_rmw");
      add(0, enc_i(32'd2, 5'd8, 3'd1, 5'd12, OP_LD), 32'h68, 1, 0, 32'h102,      32'h0,         "lh");
      add(0, enc_i(32'd2, 5'd8, 3'd5, 5'd13, OP_LD), 32'h6C, 1, 0, 32'h102,      32'h0,         "lhu");
      add(0, enc_s(32'd0, 5'd12, 5'd0, 3'd2),        32'h70, 0, 1, 32'h0,        32'hFFFF_FFFF, "lh_val");
      add(0, enc_s(32'd0, 5'd13, 5'd0, 3'd2),        32'h74, 0, 1, 32'h0,        32'h0000_FFFF, "lhu_val");
      add(0, enc_i(32'h40, 5'd0, 3'd0, 5'd1, OP_IMM), 32'h78, 0, 0, 32'h0,       32'h0,         "addi_40");
      add(0, enc_i(32'd3, 5'd1, 3'd0, 5'd1, 7'b1100111), 32'h7C, 0, 0, 32'h0,    32'h0,         "jalr");
      add(0, enc_s(32'd0, 5'd1, 5'd0, 3'd2),         32'h42, 0, 1, 32'h0,        32'h80,        "jalr_link");
      add(0, enc_j(32'h10, 5'd14),                   32'h46, 0, 0, 32'h0,        32'h0,         "jal");
      add(0, enc_s(32'd0, 5'd14, 5'd0, 3'd2),        32'h56, 0, 1, 32'h0,        32'h4A,        "jal_link");
      add(0, enc_b(32'd8, 5'd0, 5'd0, 3'd1),         32'h5A, 0, 0, 32'h0,        32'h0,         "bne_nt");
      add(0, enc_b(32'h20, 5'd0, 5'd3, 3'd4),        32'h5E, 0, 0, 32'h0,        32'h0,         "blt_t");
      add(0, enc_b(32'h20, 5'd0, 5'd3, 3'd6),        32'h7E, 0, 0, 32'h0,        32'h0,         "bltu_nt");
      add(0, enc_r(7'h20, 5'd1, 5'd14, 3'd0, 5'd15), 32'h82, 0, 0, 32'h0,        32'h0,         "sub");
      add(0, enc_s(32'd0, 5'd15, 5'd0, 3'd2),        32'h86, 0, 1, 32'h0,        32'hFFFF_FFCA, "sub_val");
      add(0, enc_i(32'd0, 5'd3, 3'd2, 5'd16, OP_IMM), 32'h8A, 0, 0, 32'h0,       32'h0,         "slti");
      add(0, enc_i(32'hFFF, 5'd0, 3'd3, 5'd17, OP_IMM), 32'h8E, 0, 0, 32'h0,     32'h0,         "sltiu");
      add(0, enc_r(7'h00, 5'd17, 5'd16, 3'd0, 5'd18), 32'h92, 0, 0, 32'h0,       32'h0,         "add");
      add(0, enc_s(32'd0, 5'd18, 5'd0, 3'd2),        32'h96, 0, 1, 32'h0,        32'h2,         "slt_sum");
      add(0, {20'h00001, 5'd19, 7'b0010111},         32'h9A, 0, 0, 32'h0,        32'h0,         "auipc");
      add(0, enc_s(32'd0, 5'd19, 5'd0, 3'd2),        32'h9E, 0, 1, 32'h0,        32'h109A,      "auipc_val");
      add(1, enc_s(32'd0, 5'd1, 5'd0, 3'd2),         32'hA2, 0, 0, 32'h0,        32'h0,         "reset_mid");
      add(0, enc_i(32'd5, 5'd0, 3'd0, 5'd0, OP_IMM), 32'h00, 0, 0, 32'h0,        32'h0,         "addi_x0");
      add(0, enc_s(32'd0, 5'd0, 5'd0, 3'd2),         32'h04, 0, 1, 32'h0,        32'h0,         "x0_zero");
      add(0, enc_s(32'd0, 5'd1, 5'd0, 3'd2),         32'h08, 0, 1, 32'h0,        32'h0,         "x1_cleared");
      add(0, 32'h0000_0073,                          32'h0C, 0, 0, 32'h0,        32'h0,         "ecall");
      add(0, 32'h0000_000F,                          32'h10, 0, 0, 32'h0,        32'h0,         "fence");

      reset = 1'b1;
      inst  = NOP;
      repeat (2) @(posedge clock);

      foreach (vecs[k]) begin
         @(negedge clock);
         reset = vecs[k].rst;
         inst  = vecs[k].inst;
         #1;
         check_vec(vecs[k]);
      end

      // Run forward to 0x30, spin there, then reset in the middle of the loop
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clock);
         reset = 1'b0;
         inst  = NOP;
         #1;
         if (pc === 32'h30) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL reach_0x30: got pc %h, expected 00000030 within 40 cycles", pc);
      end

      inst = 32'h0000_006F;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         #1;
         hv.rst = 1'b0; hv.inst = inst; hv.pc = 32'h30; hv.ld = 1'b0; hv.st = 1'b0;
         hv.addr = 32'h0; hv.sd = 32'h0; hv.name = "loop_spin";
         check_vec(hv);
      end

      @(negedge clock);
      reset = 1'b1;
      #1;
      hv.rst = 1'b1; hv.name = "loop_reset";
      check_vec(hv);

      @(negedge clock);
      reset = 1'b0;
      inst  = enc_i(32'd5, 5'd0, 3'd0, 5'd0, OP_IMM);
      #1;
      hv.rst = 1'b0; hv.pc = 32'h0; hv.name = "after_reset";
      check_vec(hv);

      @(negedge clock);
      inst = enc_s(32'd0, 5'd0, 5'd0, 3'd2);
      #1;
      hv.pc = 32'h4; hv.st = 1'b1; hv.sd = 32'h0; hv.name = "x0_after_loop";
      check_vec(hv);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
